// File: rtl/flash_burst_cmd.sv
`default_nettype none
// ============================================================================
//  Module   : flash_burst_cmd
//  Brief    : UART command parser that bursts flash reads over an address range
//             and streams the returned bytes downstream.
//  Revision : 1.0
// ============================================================================
module flash_burst_cmd #(
    parameter logic [7:0]  TERM_CHAR  = 8'h0D,
    parameter logic [7:0]  ABORT_CHAR = 8'h1B,
    parameter logic [23:0] ADDR_BASE  = 24'h0,
    parameter int          RD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_read,
    output logic        spi_read,
    output logic [23:0] spi_addr,
    input  logic        spi_ready,
    input  logic [7:0]  spi_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        err
);

    localparam int TW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0] c_tmo_max = TW'(RD_TIMEOUT);
    localparam logic [TW-1:0] c_tmo_one = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_LEN     = 3'd2,
        S_TERM    = 3'd3,
        S_RD_REQ  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_OUT     = 3'd6
    } state_t;

    state_t        r_state,   w_state;
    logic          r_byte_vld;
    logic [7:0]    r_byte;
    logic [23:0]   r_addr,    w_addr;
    logic [7:0]    r_len,     w_len;
    logic [2:0]    r_nib,     w_nib;
    logic [23:0]   r_cur,     w_cur;
    logic [8:0]    r_rem,     w_rem;
    logic [TW-1:0] r_tmo,     w_tmo;
    logic [7:0]    r_out_data, w_out_data;
    logic          r_abort,   w_abort;
    logic          r_err,     w_err;
    logic          w_consume;
    logic [4:0]    w_hex;
    logic          w_abort_in;

    // Returns {is_hex, nibble}
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] res;
        res = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)
            res = {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            res = {1'b1, c[3:0] + 4'd9};
        return res;
    endfunction

    // The consumed byte is registered and acted on one cycle later; the same
    // register doubles as the rx_read pulse, blocking re-consumption.
    assign w_consume = rx_valid & ~r_byte_vld;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_byte_vld <= 1'b0;
            r_byte     <= 8'h00;
            r_addr     <= 24'h0;
            r_len      <= 8'h00;
            r_nib      <= 3'd0;
            r_cur      <= 24'h0;
            r_rem      <= 9'd0;
            r_tmo      <= '0;
            r_out_data <= 8'h00;
            r_abort    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_byte_vld <= w_consume;
            r_byte     <= w_consume ? rx_data : r_byte;
            r_addr     <= w_addr;
            r_len      <= w_len;
            r_nib      <= w_nib;
            r_cur      <= w_cur;
            r_rem      <= w_rem;
            r_tmo      <= w_tmo;
            r_out_data <= w_out_data;
            r_abort    <= w_abort;
            r_err      <= w_err;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_len      = r_len;
        w_nib      = r_nib;
        w_cur      = r_cur;
        w_rem      = r_rem;
        w_tmo      = r_tmo;
        w_out_data = r_out_data;
        w_abort    = r_abort;
        w_err      = 1'b0;
        w_hex      = hex_decode(r_byte);
        w_abort_in = r_byte_vld && (r_byte == ABORT_CHAR);

        case (r_state)
            S_IDLE: begin
                if (r_byte_vld && (r_byte == 8'h52 || r_byte == 8'h72)) begin
                    w_state = S_ADDR;
                    w_addr  = 24'h0;
                    w_len   = 8'h00;
                    w_nib   = 3'd0;
                end
            end
            S_ADDR: begin
                if (r_byte_vld) begin
                    if (w_hex[4]) begin
                        w_addr = {r_addr[19:0], w_hex[3:0]};
                        if (r_nib == 3'd5) begin
                            w_nib   = 3'd0;
                            w_state = S_LEN;
                        end else begin
                            w_nib = r_nib + 3'd1;
                        end
                    end else begin
                        w_err   = 1'b1;
                        w_state = S_IDLE;
                    end
                end
            end
            S_LEN: begin
                if (r_byte_vld) begin
                    if (w_hex[4]) begin
                        w_len = {r_len[3:0], w_hex[3:0]};
                        if (r_nib == 3'd1) begin
                            w_nib   = 3'd0;
                            w_state = S_TERM;
                        end else begin
                            w_nib = r_nib + 3'd1;
                        end
                    end else begin
                        w_err   = 1'b1;
                        w_state = S_IDLE;
                    end
                end
            end
            S_TERM: begin
                if (r_byte_vld) begin
                    if (r_byte == TERM_CHAR) begin
                        w_state = S_RD_REQ;
                        w_cur   = r_addr + ADDR_BASE;
                        w_rem   = (r_len == 8'h00) ? 9'd256 : {1'b0, r_len};
                    end else begin
                        w_err   = 1'b1;
                        w_state = S_IDLE;
                    end
                end
            end
            S_RD_REQ: begin
                if (w_abort_in)
                    w_abort = 1'b1;
                w_tmo   = '0;
                w_state = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (w_abort_in)
                    w_abort = 1'b1;
                if (spi_ready) begin
                    w_out_data = spi_data;
                    w_state    = S_OUT;
                end else if (r_tmo == c_tmo_max) begin
                    w_err   = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_tmo = r_tmo + c_tmo_one;
                end
            end
            S_OUT: begin
                if (w_abort_in)
                    w_abort = 1'b1;
                if (out_ready) begin
                    w_cur = r_cur + 24'd1;
                    w_rem = r_rem - 9'd1;
                    // An abort landing on the final transfer ends the same way
                    if (r_rem == 9'd1 || r_abort || w_abort_in)
                        w_state = S_IDLE;
                    else
                        w_state = S_RD_REQ;
                end
            end
            default: w_state = S_IDLE;
        endcase

        if (w_state == S_IDLE)
            w_abort = 1'b0;
    end

    assign rx_read   = r_byte_vld;
    assign spi_read  = (r_state == S_RD_REQ);
    assign spi_addr  = r_cur;
    assign out_valid = (r_state == S_OUT);
    assign out_data  = r_out_data;
    assign busy      = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT) || (r_state == S_OUT);
    assign err       = r_err;

endmodule
`default_nettype wire
